// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: signal bundle between the UART receiver / host logic and
// the uart_rx_fifo buffer. The slave modport is the buffer side, the master
// modport is the side that drives received bytes and read requests.
// Optional macro UART_RX_FIFO_DROP_CNT_EN adds the drop_cnt status output.
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          rx_data;
    logic                rx_status;
    logic                rd_en;
    logic [7:0]          rd_data;
    logic                rd_valid;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                ovf_clr;
`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0]          drop_cnt;

    modport master (
        output rx_data, rx_status, rd_en, ovf_clr,
        input  rd_data, rd_valid, empty, full, count, overflow, drop_cnt
    );

    modport slave (
        input  rx_data, rx_status, rd_en, ovf_clr,
        output rd_data, rd_valid, empty, full, count, overflow, drop_cnt
    );
`else
    modport master (
        output rx_data, rx_status, rd_en, ovf_clr,
        input  rd_data, rd_valid, empty, full, count, overflow
    );

    modport slave (
        input  rx_data, rx_status, rd_en, ovf_clr,
        output rd_data, rd_valid, empty, full, count, overflow
    );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures each byte completed by the 16x-oversampled UART
// receiver (rx_status rising edge, then a fixed settle delay) and queues it
// in a circular buffer with a registered read port, occupancy count and a
// sticky overflow flag. Everything runs on baud_clk, same as the receiver.
// Optional macro UART_RX_FIFO_DROP_CNT_EN adds a saturating 8-bit counter of
// dropped bytes (drop_cnt), cleared together with overflow by ovf_clr.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int CAPTURE_DLY = 2
) (
    input  logic           baud_clk,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [3:0]          DLY_END  = 4'(CAPTURE_DLY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PUSH = 2'd2
    } state_t;

    // Saturating increment used by the drop counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Occupancy step: +1 for a write alone, -1 for a read alone.
    function automatic logic [DEPTH_LOG2:0] count_step(
        input logic [DEPTH_LOG2:0] c,
        input logic                wr,
        input logic                rd
    );
        logic [DEPTH_LOG2:0] r;
        r = c;
        if (wr && !rd)
            r = c + 1'b1;
        else if (!wr && rd)
            r = c - 1'b1;
        return r;
    endfunction

    state_t                state_q, state_d;
    logic [3:0]            dly_q, dly_d;
    logic                  status_q;
    logic                  armed_q;
    logic                  rise_p0;
    logic                  push_p0;
    logic                  pop_p0;
    logic                  wr_ok_p0;
    logic                  drop_p0;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [7:0]            rd_data_p1;
    logic                  rd_valid_p1;
    logic                  overflow_q;
    logic                  empty_w;
    logic                  full_w;

    // ---- stage p0: edge detect, capture FSM, write/read arbitration ----

    // armed_q suppresses the first cycle after reset release, so a rx_status
    // that is already high then is taken as a level, not as a new frame.
    assign rise_p0 = bus.rx_status & ~status_q & armed_q;

    assign empty_w  = (count_q == '0);
    assign full_w   = (count_q == FULL_CNT);
    assign pop_p0   = bus.rd_en & ~empty_w;
    // When full, a same-cycle pop frees the slot the new byte goes into.
    assign wr_ok_p0 = push_p0 & (~full_w | pop_p0);
    assign drop_p0  = push_p0 & full_w & ~pop_p0;

    // Edge-detect history and capture FSM state register.
    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset) begin
            status_q <= 1'b0;
            armed_q  <= 1'b0;
            state_q  <= ST_IDLE;
            dly_q    <= 4'd0;
        end else begin
            status_q <= bus.rx_status;
            armed_q  <= 1'b1;
            state_q  <= state_d;
            dly_q    <= dly_d;
        end
    end

    // Capture FSM next state: wait CAPTURE_DLY cycles after a rise, then push.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        push_p0 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise_p0) begin
                    dly_d   = 4'd1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dly_q == DLY_END)
                    state_d = ST_PUSH;
                else
                    dly_d = dly_q + 4'd1;
            end
            ST_PUSH: begin
                push_p0 = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---- stage p1: buffer update and registered read port ----

    // Buffer storage; contents are intentionally left uninitialised by reset.
    always_ff @(posedge baud_clk) begin
        if (wr_ok_p0)
            mem[wr_ptr_q] <= bus.rx_data;
    end

    // Pointers, occupancy, read data/valid and sticky overflow.
    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_p1  <= 8'h00;
            rd_valid_p1 <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (wr_ok_p0)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_p0) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                rd_data_p1 <= mem[rd_ptr_q];
            end
            rd_valid_p1 <= pop_p0;
            count_q     <= count_step(count_q, wr_ok_p0, pop_p0);
            if (drop_p0)
                overflow_q <= 1'b1;
            else if (bus.ovf_clr)
                overflow_q <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    // Dropped-byte counter; a clear coinciding with a drop leaves one drop.
    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset)
            drop_cnt_q <= 8'd0;
        else if (bus.ovf_clr)
            drop_cnt_q <= drop_p0 ? 8'd1 : 8'd0;
        else if (drop_p0)
            drop_cnt_q <= sat_inc8(drop_cnt_q);
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

    assign bus.rd_data  = rd_data_p1;
    assign bus.rd_valid = rd_valid_p1;
    assign bus.empty    = empty_w;
    assign bus.full     = full_w;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scoreboard bench for uart_rx_fifo. Read requests
// push their hand-computed expected byte into a queue; a monitor pops and
// compares on every rd_valid pulse. Status outputs are checked directly.
module tb_uart_rx_fifo;

    localparam int DL2 = 4;

    logic baud_clk = 1'b0;
    logic reset    = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    uart_rx_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

    uart_rx_fifo #(.DEPTH_LOG2(DL2), .CAPTURE_DLY(2)) dut (
        .baud_clk (baud_clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 baud_clk = ~baud_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every read pulse must match the oldest expected byte.
    always @(negedge baud_clk) begin
        if (reset && bus.rd_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got rd_valid with data 0x%0h, expected no pulse", bus.rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.rd_data !== e) begin
                    n_err++;
                    $display("FAIL rd_data: got 0x%0h, expected 0x%0h", bus.rd_data, e);
                end
            end
        end
    end

    // One frame: rise, optional rd_en / ovf_clr on the push cycle, then low.
    task automatic frame(input logic [7:0] b, input bit rd, input logic [7:0] exp_rd, input bit clr);
        @(negedge baud_clk);
        bus.rx_data   = b;
        bus.rx_status = 1'b1;
        repeat (3) @(negedge baud_clk);
        if (rd) begin
            bus.rd_en = 1'b1;
            exp_q.push_back(exp_rd);
        end
        if (clr)
            bus.ovf_clr = 1'b1;
        @(negedge baud_clk);
        bus.rd_en     = 1'b0;
        bus.ovf_clr   = 1'b0;
        bus.rx_status = 1'b0;
    endtask

    task automatic do_read(input bit expect_data, input logic [7:0] exp_rd);
        @(negedge baud_clk);
        bus.rd_en = 1'b1;
        if (expect_data)
            exp_q.push_back(exp_rd);
        @(negedge baud_clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic clr_pulse();
        @(negedge baud_clk);
        bus.ovf_clr = 1'b1;
        @(negedge baud_clk);
        bus.ovf_clr = 1'b0;
    endtask

    initial begin
        bus.rx_data   = 8'h00;
        bus.rx_status = 1'b1;
        bus.rd_en     = 1'b0;
        bus.ovf_clr   = 1'b0;

        // Reset release with rx_status already high: no push.
        repeat (3) @(negedge baud_clk);
        reset = 1'b1;
        repeat (8) @(negedge baud_clk);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_rd_data", int'(bus.rd_data), 0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("rst_drop_cnt", int'(bus.drop_cnt), 0);
`endif
        bus.rx_status = 1'b0;
        @(negedge baud_clk);

        // Single byte: push lands CAPTURE_DLY+1 cycles after the rise cycle.
        @(negedge baud_clk);
        bus.rx_data   = 8'h55;
        bus.rx_status = 1'b1;
        repeat (3) @(negedge baud_clk);
        chk("lat_before_push", int'(bus.count), 0);
        @(negedge baud_clk);
        chk("lat_after_push", int'(bus.count), 1);
        chk("one_empty", int'(bus.empty), 0);
        bus.rx_status = 1'b0;
        do_read(1'b1, 8'h55);
        chk("one_drained_empty", int'(bus.empty), 1);

        // Fill 16, drop the 17th, read back in order.
        for (int i = 0; i < 16; i++)
            frame(8'(i), 1'b0, 8'h00, 1'b0);
        chk("fill_full", int'(bus.full), 1);
        chk("fill_count", int'(bus.count), 16);
        chk("fill_no_ovf", int'(bus.overflow), 0);
        frame(8'hAA, 1'b0, 8'h00, 1'b0);
        chk("drop_ovf", int'(bus.overflow), 1);
        chk("drop_count", int'(bus.count), 16);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("drop_cnt_one", int'(bus.drop_cnt), 1);
`endif
        for (int i = 0; i < 16; i++)
            do_read(1'b1, 8'(i));
        chk("drain_empty", int'(bus.empty), 1);
        chk("drain_count", int'(bus.count), 0);
        // Read while empty: no pulse, data holds.
        do_read(1'b0, 8'h00);
        chk("empty_rd_hold", int'(bus.rd_data), 8'h0F);
        chk("empty_rd_count", int'(bus.count), 0);

        // Clear, refill, then push coincident with a read while full.
        clr_pulse();
        chk("clr_ovf", int'(bus.overflow), 0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("clr_drop_cnt", int'(bus.drop_cnt), 0);
`endif
        for (int i = 0; i < 16; i++)
            frame(8'(8'h10 + i), 1'b0, 8'h00, 1'b0);
        frame(8'hBB, 1'b1, 8'h10, 1'b0);
        @(negedge baud_clk);
        chk("full_rw_count", int'(bus.count), 16);
        chk("full_rw_ovf", int'(bus.overflow), 0);
        chk("full_rw_full", int'(bus.full), 1);
        for (int i = 1; i < 16; i++)
            do_read(1'b1, 8'(8'h10 + i));
        do_read(1'b1, 8'hBB);
        chk("full_rw_empty", int'(bus.empty), 1);

        // Interleaved write/read pairs across the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            frame(8'(8'h30 + i), 1'b0, 8'h00, 1'b0);
            chk("wrap_count1", int'(bus.count), 1);
            do_read(1'b1, 8'(8'h30 + i));
            chk("wrap_count0", int'(bus.count), 0);
        end

        // Reset during WAIT abandons the byte; high rx_status after is no rise.
        @(negedge baud_clk);
        bus.rx_data   = 8'h77;
        bus.rx_status = 1'b1;
        repeat (2) @(negedge baud_clk);
        reset = 1'b0;
        @(negedge baud_clk);
        reset = 1'b1;
        repeat (8) @(negedge baud_clk);
        chk("midrst_count", int'(bus.count), 0);
        chk("midrst_empty", int'(bus.empty), 1);
        chk("midrst_rd_data", int'(bus.rd_data), 0);
        bus.rx_status = 1'b0;
        @(negedge baud_clk);

        // Overflow set-wins-over-clear, then clear alone.
        for (int i = 0; i < 16; i++)
            frame(8'(8'h40 + i), 1'b0, 8'h00, 1'b0);
        frame(8'hE0, 1'b0, 8'h00, 1'b0);
        frame(8'hE1, 1'b0, 8'h00, 1'b0);
        chk("ovf_set", int'(bus.overflow), 1);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("drop_cnt_two", int'(bus.drop_cnt), 2);
`endif
        frame(8'hE2, 1'b0, 8'h00, 1'b1);
        chk("ovf_clr_and_drop", int'(bus.overflow), 1);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("drop_cnt_clr_drop", int'(bus.drop_cnt), 1);
`endif
        clr_pulse();
        chk("ovf_clr_alone", int'(bus.overflow), 0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("drop_cnt_clr_alone", int'(bus.drop_cnt), 0);
        for (int i = 0; i < 260; i++)
            frame(8'hF0, 1'b0, 8'h00, 1'b0);
        chk("drop_cnt_sat", int'(bus.drop_cnt), 255);
        clr_pulse();
`endif
        for (int i = 0; i < 16; i++)
            do_read(1'b1, 8'(8'h40 + i));
        chk("final_empty", int'(bus.empty), 1);

        repeat (4) @(negedge baud_clk);
        chk("sb_outstanding", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Downstream consumer of the 16x-oversampled UART receiver's rx_data/rx_status outputs.
- Detects each completed frame, captures the byte after a fixed settle delay, and queues it in a circular buffer.
- Exposes a registered read handshake, occupancy count and a sticky overflow flag to the host-side logic.
- Whole block runs on baud_clk, the same clock as the receiver, so no synchronisers are needed.

Parameters:
- DEPTH_LOG2, 4, log2 of buffer depth (depth = 16 entries).
- CAPTURE_DLY, 2, baud_clk cycles from detected rx_status rise to data capture; legal range 1..15.

Ports:
- baud_clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-low.
- rx_data  input  8  byte from the receiver, LSB first shifted, valid once settled after rx_status rises.
- rx_status  input  1  receiver frame-done level; a 0->1 transition marks a new byte.
- rd_en  input  1  host read request.
- rd_data  output  8  registered read data.
- rd_valid  output  1  one-cycle pulse, rd_data valid.
- empty  output  1  buffer holds 0 entries.
- full  output  1  buffer holds 2^DEPTH_LOG2 entries.
- count  output  DEPTH_LOG2+1  current occupancy.
- overflow  output  1  sticky, set when a byte was dropped.
- ovf_clr  input  1  clears overflow.

Behaviour:
- Reset (async, reset low):
  - Clears FSM (to IDLE), status_q, delay counter, wr/rd pointers, count, rd_data (0x00), rd_valid, overflow.
  - empty=1, full=0.
  - Memory contents are not cleared.
  - Reset mid-capture abandons the pending byte.
- Edge detect: status_q <= rx_status each cycle; rise = rx_status & ~status_q. A rx_status already high at reset release is not a rise.
- Capture FSM:
  - IDLE: on rise, load dly_cnt=1 and go to WAIT.
  - WAIT: dly_cnt increments each cycle. When dly_cnt==CAPTURE_DLY, go to PUSH. Rises seen during WAIT are ignored.
  - PUSH: one cycle. Asserts push with rx_data sampled in that cycle, then returns to IDLE.
  - Latency from rise cycle to push cycle = CAPTURE_DLY+1; count updates at the end of the push cycle.
- Write:
  - push with full=0: mem[wr_ptr]<=rx_data, wr_ptr+1 (wraps modulo depth).
  - push with full=1 and no accepted pop in the same cycle: byte dropped, overflow<=1.
- Read:
  - rd_en with empty=0: rd_data<=mem[rd_ptr], rd_ptr+1 (wraps), rd_valid=1 the next cycle.
  - rd_en with empty=1: ignored; rd_valid=0 and rd_data holds.
- Simultaneous push and pop:
  - Both are accepted, including when full (the freed slot takes the new byte), and count is unchanged.
  - When empty, the pop is rejected and the push proceeds, so count becomes 1.
- count: +1 on push only, -1 on pop only; never exceeds 2^DEPTH_LOG2. empty=(count==0), full=(count==2^DEPTH_LOG2), both registered-derived.
- overflow: ovf_clr clears it. If a drop and ovf_clr occur in the same cycle, set wins.
- Pointers are DEPTH_LOG2 bits wide; count carries the extra bit.

Optional Feature:
- Macro: UART_RX_FIFO_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt[7:0], reset 0.
  - Increments on every dropped byte and saturates at 255.
  - ovf_clr clears it to 0; a drop in the same cycle as ovf_clr gives 1.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release with rx_status held 1 -> no push; count=0, empty=1, rd_valid never pulses.
- rx_data=0x55 with one rx_status rise at cycle T -> push at cycle T+3 (CAPTURE_DLY=2); count=1. rd_en at T+5 -> rd_data=0x55, rd_valid=1 at T+6, empty=1.
- 16 frames 0x00..0x0F, no reads -> full=1, count=16. 17th frame 0xAA -> dropped, overflow=1, (DROP_CNT_EN) drop_cnt=1. Reading 16 times returns 0x00..0x0F in order.
- Full buffer, push of 0xBB coincident with rd_en -> rd_data=oldest byte, count stays 16, overflow unchanged. After draining, last byte read = 0xBB.
- Wrap: 20 write/read pairs interleaved -> data matches order across the pointer wrap; count toggles 0/1.
- reset pulsed low during WAIT -> no push after release. overflow set then ovf_clr together with a drop -> overflow stays 1; ovf_clr alone -> 0.
